grid_merge_engine: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle summation stage of the 2048 game logic.
- Performs the full move on an N x N board in one transaction: compress, single-pass merge, compress. The caller no longer has to loop on a ready flag.
- Processes one line per clock through a shared line merger.
- Reports the moved flag, score delta and win flag. Sits between the input/direction decoder and the tile spawner.

---
 rtl/grid_pkg.sv | 20 ++
 rtl/grid_merge_engine_if.sv | 35 +++
 rtl/line_merge.sv | 69 ++++++
 rtl/grid_merge_engine.sv | 138 +++++++++++++
 tb/tb_grid_merge_engine.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_pkg.sv
// Shared types, direction encodings and width helpers for the grid merge engine.
package grid_pkg;

  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {IDLE, PROC, DONE} merge_state_t;

  // Score holds every tile doubling in one move, so it needs log2(tiles) headroom.
  function automatic int unsigned score_width(input int unsigned n, input int unsigned w);
    return w + $clog2(n * n);
  endfunction

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n * n / 2 + 1);
  endfunction

endpackage

// File: rtl/grid_merge_engine_if.sv
// Request/response bundle between the direction decoder, the merge engine and the spawner.
// GRID_MERGE_STATS_EN adds the merge_count response field.
interface grid_merge_engine_if
  import grid_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 12
);
  localparam int unsigned SW = score_width(N, W);
  localparam int unsigned CW = count_width(N);

  logic                           start;
  logic [3:0]                     direction;
  logic [N-1:0][N-1:0][W-1:0]     matrix;
  logic [N-1:0][N-1:0][W-1:0]     result;
  logic                           busy;
  logic                           done;
  logic                           moved;
  logic [SW-1:0]                  score_delta;
  logic                           win;
`ifdef GRID_MERGE_STATS_EN
  logic [CW-1:0]                  merge_count;

  modport master (output start, direction, matrix,
                  input  result, busy, done, moved, score_delta, win, merge_count);
  modport slave  (input  start, direction, matrix,
                  output result, busy, done, moved, score_delta, win, merge_count);
`else
  modport master (output start, direction, matrix,
                  input  result, busy, done, moved, score_delta, win);
  modport slave  (input  start, direction, matrix,
                  output result, busy, done, moved, score_delta, win);
`endif

endinterface

// File: rtl/line_merge.sv
// Combinational 2048 line merge: compress toward element 0, single-pass pairwise merge, compress.
module line_merge
  import grid_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 12,
  parameter int unsigned WIN_VALUE = 2048,
  localparam int unsigned SW       = score_width(N, W),
  localparam int unsigned CW       = count_width(N)
) (
  input  logic [N-1:0][W-1:0] i_line,
  output logic [N-1:0][W-1:0] o_line_c,
  output logic                o_changed_c,
  output logic [SW-1:0]       o_score_c,
  output logic                o_win_c,
  output logic [CW-1:0]       o_merges_c
);

  // The top tile value is saturated: merging it would overflow W bits.
  localparam logic [W-1:0] SAT_VALUE = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] WIN_TILE  = W'(WIN_VALUE);

  logic [N-1:0][W-1:0] w_t;
  logic                w_skip;

  always_comb begin
    w_t         = i_line;
    w_skip      = 1'b0;
    o_score_c   = '0;
    o_win_c     = 1'b0;
    o_merges_c  = '0;

    // Bubble compaction keeps tile order with constant indices only.
    for (int p = 0; p < N - 1; p++) begin
      for (int j = 0; j < N - 1; j++) begin
        if (w_t[j] == '0) begin
          w_t[j]   = w_t[j+1];
          w_t[j+1] = '0;
        end
      end
    end

    for (int m = 0; m < N - 1; m++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_t[m] != '0 && w_t[m] == w_t[m+1] && w_t[m] != SAT_VALUE) begin
        w_t[m]     = w_t[m] << 1;
        w_t[m+1]   = '0;
        o_score_c  = o_score_c + SW'(w_t[m]);
        o_merges_c = o_merges_c + CW'(1);
        if (w_t[m] == WIN_TILE) o_win_c = 1'b1;
        w_skip = 1'b1;
      end
    end

    for (int p = 0; p < N - 1; p++) begin
      for (int j = 0; j < N - 1; j++) begin
        if (w_t[j] == '0) begin
          w_t[j]   = w_t[j+1];
          w_t[j+1] = '0;
        end
      end
    end

    o_line_c    = w_t;
    o_changed_c = (w_t != i_line);
  end

endmodule

// File: rtl/grid_merge_engine.sv
// Multi-cycle 2048 board move: one line per clock through a shared line_merge.
// GRID_MERGE_STATS_EN adds a per-move merge counter on the interface.
module grid_merge_engine
  import grid_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 12,
  parameter int unsigned WIN_VALUE = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  grid_merge_engine_if.slave bus
);

  localparam int unsigned SW = score_width(N, W);
  localparam int unsigned CW = count_width(N);
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  merge_state_t                r_state;
  logic [KW-1:0]               r_k;
  logic [3:0]                  r_dir;
  logic [N-1:0][N-1:0][W-1:0]  r_work;
  logic                        r_moved;
  logic                        r_win;
  logic [SW-1:0]               r_score;
  logic [CW-1:0]               r_merges;

  logic [N-1:0][W-1:0]         w_line_in;
  logic [N-1:0][W-1:0]         w_line_out;
  logic                        w_changed;
  logic [SW-1:0]               w_score;
  logic                        w_win;
  logic [CW-1:0]               w_merges;
  logic [N-1:0][N-1:0][W-1:0]  w_work_next;

  // Line k in canonical order; a non-one-hot direction yields an all-empty line, so nothing moves.
  always_comb begin
    w_line_in = '0;
    for (int m = 0; m < N; m++) begin
      case (r_dir)
        DIR_DOWN:  w_line_in[m] = r_work[m][r_k];
        DIR_UP:    w_line_in[m] = r_work[N-1-m][r_k];
        DIR_LEFT:  w_line_in[m] = r_work[r_k][m];
        DIR_RIGHT: w_line_in[m] = r_work[r_k][N-1-m];
        default:   w_line_in[m] = '0;
      endcase
    end
  end

  line_merge #(.N(N), .W(W), .WIN_VALUE(WIN_VALUE)) u_line_merge (
    .i_line      (w_line_in),
    .o_line_c    (w_line_out),
    .o_changed_c (w_changed),
    .o_score_c   (w_score),
    .o_win_c     (w_win),
    .o_merges_c  (w_merges)
  );

  always_comb begin
    w_work_next = r_work;
    for (int m = 0; m < N; m++) begin
      case (r_dir)
        DIR_DOWN:  w_work_next[m][r_k]     = w_line_out[m];
        DIR_UP:    w_work_next[N-1-m][r_k] = w_line_out[m];
        DIR_LEFT:  w_work_next[r_k][m]     = w_line_out[m];
        DIR_RIGHT: w_work_next[r_k][N-1-m] = w_line_out[m];
        default:   ;
      endcase
    end
  end

  // Outputs publish only on the last line so the spawner never sees a partial board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_k             <= '0;
      r_dir           <= '0;
      r_work          <= '0;
      r_moved         <= 1'b0;
      r_win           <= 1'b0;
      r_score         <= '0;
      r_merges        <= '0;
      bus.result      <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.moved       <= 1'b0;
      bus.score_delta <= '0;
      bus.win         <= 1'b0;
`ifdef GRID_MERGE_STATS_EN
      bus.merge_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            r_work   <= bus.matrix;
            r_dir    <= bus.direction;
            r_k      <= '0;
            r_moved  <= 1'b0;
            r_win    <= 1'b0;
            r_score  <= '0;
            r_merges <= '0;
            bus.busy <= 1'b1;
            r_state  <= PROC;
          end
        end
        PROC: begin
          r_work   <= w_work_next;
          r_moved  <= r_moved | w_changed;
          r_win    <= r_win | w_win;
          r_score  <= r_score + w_score;
          r_merges <= r_merges + w_merges;
          r_k      <= r_k + KW'(1);
          if (r_k == KW'(N - 1)) begin
            bus.result      <= w_work_next;
            bus.moved       <= r_moved | w_changed;
            bus.win         <= r_win | w_win;
            bus.score_delta <= r_score + w_score;
`ifdef GRID_MERGE_STATS_EN
            bus.merge_count <= r_merges + w_merges;
`endif
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            r_k             <= '0;
            r_state         <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_merge_engine.sv
// Scoreboard bench for grid_merge_engine against a queue-based move model.
module tb_grid_merge_engine;
  import grid_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 12;
  localparam int unsigned WINV = 2048;
  localparam int unsigned SW   = score_width(N, W);

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
  typedef struct {
    mat_t          res;
    logic          moved;
    logic [SW-1:0] score;
    logic          win;
    int unsigned   mc;
    int unsigned   cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  grid_merge_engine_if #(.N(N), .W(W)) bif ();
  grid_merge_engine #(.N(N), .W(W), .WIN_VALUE(WINV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_issued = 0;
  mat_t prev_res = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void coord(input logic [3:0] d, input int k, input int m,
                                output int r, output int c);
    case (d)
      DIR_DOWN:  begin r = m;         c = k;         end
      DIR_UP:    begin r = N - 1 - m; c = k;         end
      DIR_LEFT:  begin r = k;         c = m;         end
      DIR_RIGHT: begin r = k;         c = N - 1 - m; end
      default:   begin r = k;         c = m;         end
    endcase
  endfunction

  // Slide each line: keep non-empty tiles in order, fuse equal neighbours once, pad with zeros.
  function automatic exp_t ref_move(input mat_t m, input logic [3:0] d, input int unsigned c_exp);
    exp_t e;
    int   q[$];
    int   o[$];
    int   r, c, sc, i;
    e.res = m; e.win = 1'b0; e.mc = 0; e.cyc = c_exp; sc = 0;
    if (d == DIR_LEFT || d == DIR_DOWN || d == DIR_UP || d == DIR_RIGHT) begin
      for (int k = 0; k < N; k++) begin
        q.delete(); o.delete();
        for (int j = 0; j < N; j++) begin
          coord(d, k, j, r, c);
          if (m[r][c] != 0) q.push_back(int'(m[r][c]));
        end
        i = 0;
        while (i < q.size()) begin
          if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != (1 << (W - 1))) begin
            o.push_back(2 * q[i]);
            sc += 2 * q[i];
            e.mc++;
            if (2 * q[i] == WINV) e.win = 1'b1;
            i += 2;
          end else begin
            o.push_back(q[i]);
            i += 1;
          end
        end
        while (o.size() < N) o.push_back(0);
        for (int j = 0; j < N; j++) begin
          coord(d, k, j, r, c);
          e.res[r][c] = W'(o[j]);
        end
      end
    end
    e.moved = (e.res != m);
    e.score = SW'(sc);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bif.done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", 256'(bif.result), 256'(e.res));
        chk("moved", 256'(bif.moved), 256'(e.moved));
        chk("score_delta", 256'(bif.score_delta), 256'(e.score));
        chk("win", 256'(bif.win), 256'(e.win));
        chk("done_cycle", 256'(cyc), 256'(e.cyc));
        chk("busy_at_done", 256'(bif.busy), 256'(0));
`ifdef GRID_MERGE_STATS_EN
        chk("merge_count", 256'(bif.merge_count), 256'(e.mc));
`endif
      end
    end
  end

  function automatic mat_t rand_mat();
    mat_t m;
    int   r;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        r = $urandom_range(0, 9);
        if (r < 4)       m[a][b] = '0;
        else if (r == 9) m[a][b] = W'(1) << $urandom_range(10, 11);
        else             m[a][b] = W'(1) << $urandom_range(1, 5);
      end
    return m;
  endfunction

  task automatic wait_dones(input int target, input string name);
    for (int i = 0; i < 60 && n_done < target; i++) @(posedge clk);
    if (n_done < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d dones expected %0d", name, n_done, target);
      sb.delete();
    end
  endtask

  task automatic issue(input mat_t m, input logic [3:0] d, input bit poke_busy, input string name);
    exp_t e;
    int   base;
    base = n_done;
    @(posedge clk); #1;
    bif.matrix = m; bif.direction = d; bif.start = 1'b1;
    e = ref_move(m, d, cyc + N + 1);
    sb.push_back(e);
    n_issued++;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bif.matrix = rand_mat();
    bif.direction = DIR_RIGHT;
    chk({name, "_busy"}, 256'(bif.busy), 256'(1));
    chk({name, "_held"}, 256'(bif.result), 256'(prev_res));
    if (poke_busy) begin
      @(posedge clk); #1;
      bif.start = 1'b1; bif.matrix = rand_mat(); bif.direction = DIR_LEFT;
      @(posedge clk); #1;
      bif.start = 1'b0;
    end
    wait_dones(base + 1, name);
    prev_res = e.res;
    @(posedge clk); #1;
  endtask

  mat_t m;
  int   base;
  exp_t e1, e2;
  logic [3:0] dirs[6];

  initial begin
    dirs[0] = DIR_LEFT; dirs[1] = DIR_DOWN; dirs[2] = DIR_UP;
    dirs[3] = DIR_RIGHT; dirs[4] = 4'b0000; dirs[5] = 4'b0101;
    bif.start = 1'b0; bif.direction = '0; bif.matrix = '0;
    #12;
    chk("reset_busy", 256'(bif.busy), 256'(0));
    chk("reset_done", 256'(bif.done), 256'(0));
    chk("reset_result", 256'(bif.result), 256'(0));
    rst_n = 1'b1;

    // Abort mid-move: no done, outputs back to reset values.
    m = rand_mat();
    @(posedge clk); #1;
    bif.matrix = m; bif.direction = DIR_LEFT; bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 256'(bif.busy), 256'(0));
    chk("abort_done", 256'(bif.done), 256'(0));
    chk("abort_result", 256'(bif.result), 256'(0));
    chk("abort_score", 256'(bif.score_delta), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    chk("abort_no_done", 256'(n_done), 256'(0));

    m = '0;
    for (int c = 0; c < N; c++) m[0][c] = W'(2);
    issue(m, DIR_LEFT, 1'b0, "left_2222");
    chk("left_2222_score", 256'(bif.score_delta), 256'(8));
    chk("left_2222_row0", 256'(bif.result[0]), 256'({W'(0), W'(0), W'(4), W'(4)}));

    m = '0; m[0][0] = W'(2); m[1][0] = W'(2); m[2][0] = W'(4);
    issue(m, DIR_DOWN, 1'b0, "down_224");
    chk("down_224_score", 256'(bif.score_delta), 256'(4));
    chk("down_224_win", 256'(bif.win), 256'(0));

    m = '0; m[3][0] = W'(1024); m[3][1] = W'(1024);
    issue(m, DIR_RIGHT, 1'b0, "right_win");
    chk("right_win_flag", 256'(bif.win), 256'(1));
    chk("right_win_tile", 256'(bif.result[3][3]), 256'(2048));

    m = '0; m[1][0] = W'(2048); m[1][1] = W'(2048);
    issue(m, DIR_LEFT, 1'b0, "saturate");
    chk("saturate_moved", 256'(bif.moved), 256'(0));

    m = '0; m[3][0] = W'(2); m[2][0] = W'(4); m[3][2] = W'(8);
    issue(m, DIR_UP, 1'b1, "up_stuck");
    chk("up_stuck_moved", 256'(bif.moved), 256'(0));
    chk("up_stuck_result", 256'(bif.result), 256'(m));

    issue(rand_mat(), 4'b0011, 1'b1, "bad_dir");
    chk("bad_dir_moved", 256'(bif.moved), 256'(0));

    m = '0;
    for (int r = 0; r < N; r++) begin
      m[r][0] = W'(4); m[r][1] = W'(4); m[r][2] = W'(8); m[r][3] = W'(8);
    end
    issue(m, DIR_LEFT, 1'b0, "stats");
    chk("stats_score", 256'(bif.score_delta), 256'(96));

    // Start held high: the IDLE cycle right after DONE accepts the next move.
    m = rand_mat();
    base = n_done;
    @(posedge clk); #1;
    bif.matrix = m; bif.direction = DIR_DOWN; bif.start = 1'b1;
    e1 = ref_move(m, DIR_DOWN, cyc + N + 1);
    e2 = ref_move(m, DIR_DOWN, cyc + 2 * N + 3);
    sb.push_back(e1); sb.push_back(e2);
    n_issued += 2;
    repeat (N + 3) @(posedge clk);
    #1 bif.start = 1'b0;
    wait_dones(base + 2, "b2b");
    prev_res = e2.res;
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++)
      issue(rand_mat(), dirs[$urandom_range(0, 5)], 1'(t % 5 == 0), "rand");

    repeat (10) @(posedge clk);
    chk("done_count", 256'(n_done), 256'(n_issued));
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
